// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with a one-entry holding register and BREAK generation.
// Latency: a byte accepted on edge k starts its start bit on edge k+1 (or right after the current frame).
// Backpressure: send_ready drops while the holding register is full, a BREAK is pending, or a BREAK is on the line.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   send_en, send_data  - byte offer, taken on an edge where send_en && send_ready
//   send_ready          - holding register free
//   send_break          - request a BREAK (sets a sticky pending flag)
//   send_busy           - anything queued or on the line
//   send_done           - one-cycle pulse during the last cycle of each data frame's final stop bit
//   uart_txd            - registered serial output, idle high
module uart_tx #(
  parameter int BIT_RATE   = 9600,
  parameter int CLK_HZ     = 100000000,
  parameter int STOP_BITS  = 1,
  parameter int BREAK_BITS = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       send_ready,
  input  logic       send_break,
  output logic       send_busy,
  output logic       send_done,
  output logic       uart_txd
);

  localparam int          CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam logic [15:0] BIT_LAST       = 16'(CYCLES_PER_BIT - 1);
  localparam logic [7:0]  STOP_LAST      = 8'(STOP_BITS - 1);
  // BREAK runs BREAK_BITS low periods (index 0..BREAK_BITS-1) plus one mark period (index BREAK_BITS).
  localparam logic [7:0]  BREAK_LOW_LAST = 8'(BREAK_BITS - 1);
  localparam logic [7:0]  BREAK_MARK     = 8'(BREAK_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;          // cycle within the current bit period
  logic [7:0]  bit_cnt, bit_cnt_n;  // bit period within the current state
  logic [7:0]  shift, shift_n;
  logic [7:0]  hold;
  logic        hold_full;
  logic        break_pending;
  logic        txd_q, txd_n;
  logic        take_hold;
  logic        take_break;
  logic        done;
  logic        bit_end;
  logic        accept;

  assign send_ready = !reset && !hold_full && !break_pending && (state != BREAK);
  assign send_busy  = (state != IDLE) || hold_full || break_pending;
  assign send_done  = done;
  assign uart_txd   = txd_q;
  assign accept     = send_en && send_ready;
  assign bit_end    = (cnt == BIT_LAST);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    txd_n      = txd_q;
    take_hold  = 1'b0;
    take_break = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        // A queued byte always wins over a pending BREAK.
        if (hold_full) begin
          state_n   = START;
          shift_n   = hold;
          take_hold = 1'b1;
          txd_n     = 1'b0;
          cnt_n     = 16'd0;
        end else if (break_pending) begin
          state_n    = BREAK;
          take_break = 1'b1;
          txd_n      = 1'b0;
          cnt_n      = 16'd0;
          bit_cnt_n  = 8'd0;
        end
      end

      START: begin
        if (bit_end) begin
          state_n   = DATA;
          cnt_n     = 16'd0;
          bit_cnt_n = 8'd0;
          txd_n     = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (bit_cnt == 8'd7) begin
            state_n   = STOP;
            bit_cnt_n = 8'd0;
            txd_n     = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 8'd1;
            shift_n   = {1'b0, shift[7:1]};
            txd_n     = shift[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (bit_cnt == STOP_LAST) begin
            done      = 1'b1;
            bit_cnt_n = 8'd0;
            // Chain straight into the next frame so there is no idle gap.
            if (hold_full) begin
              state_n   = START;
              shift_n   = hold;
              take_hold = 1'b1;
              txd_n     = 1'b0;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 8'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      BREAK: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (bit_cnt == BREAK_MARK) begin
            state_n   = IDLE;
            bit_cnt_n = 8'd0;
            txd_n     = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 8'd1;
            if (bit_cnt == BREAK_LOW_LAST) begin
              txd_n = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_cnt       <= 8'd0;
      shift         <= 8'd0;
      hold          <= 8'd0;
      hold_full     <= 1'b0;
      break_pending <= 1'b0;
      txd_q         <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      txd_q   <= txd_n;

      // accept needs an empty hold, take_hold needs a full one: never both.
      if (accept) begin
        hold      <= send_data;
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end

      // A request arriving on the launch edge re-arms the flag for another BREAK.
      if (send_break) begin
        break_pending <= 1'b1;
      end else if (take_break) begin
        break_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives two uart_tx instances (1 and 2 stop bits) with the same stimulus and
// checks every output on every cycle against a line-schedule model of frames and BREAKs.
module tb_uart_tx;
  localparam int CPB  = 10;
  localparam int BB   = 11;
  localparam int NMAX = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic [7:0] send_data;
  logic       send_break;
  logic [1:0] ready, busy, done, txd;

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .STOP_BITS(1), .BREAK_BITS(BB)) dut0 (
    .clk(clk), .reset(reset), .send_en(en[0]), .send_data(send_data), .send_ready(ready[0]),
    .send_break(send_break), .send_busy(busy[0]), .send_done(done[0]), .uart_txd(txd[0]));

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .STOP_BITS(2), .BREAK_BITS(BB)) dut1 (
    .clk(clk), .reset(reset), .send_en(en[1]), .send_data(send_data), .send_ready(ready[1]),
    .send_break(send_break), .send_busy(busy[1]), .send_done(done[1]), .uart_txd(txd[1]));

  always #5 clk = ~clk;

  // Expected line: per instance, per cycle index (cycle n = interval after clock edge n).
  bit exp_txd  [0:1][0:NMAX-1];
  bit exp_done [0:1][0:NMAX-1];
  int free_at    [0:1];  // first cycle the line is no longer owned by scheduled traffic
  int busy_until [0:1];
  int hold_until [0:1];  // first cycle the most recent byte is no longer waiting in hold
  int brk_until  [0:1];  // first cycle after the most recent BREAK (pending + low + mark)
  int last_b     [0:1];  // first cycle of the most recent BREAK
  int done_cnt   [0:1];
  int low_cnt    [0:1];
  int acc_at     [0:1];
  int done_at    [0:1];
  logic [1:0] last_acc;
  int cyc;
  int errors;
  int checks;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + 8 + (i + 1)) * CPB;
  endfunction

  function automatic logic ready_exp(input int i, input int n);
    return !reset && (n >= hold_until[i]) && (n >= brk_until[i]);
  endfunction

  task automatic model_reset(input int i, input int r);
    for (int n = r; n < NMAX; n++) begin
      exp_txd[i][n]  = 1'b1;
      exp_done[i][n] = 1'b0;
    end
    free_at[i]    = r;
    busy_until[i] = r;
    hold_until[i] = r;
    brk_until[i]  = r;
    last_b[i]     = 0;
  endtask

  // Byte accepted on edge k: frame starts next cycle, or when the line frees up.
  task automatic model_byte(input int i, input int k, input logic [7:0] d);
    int s;
    int f;
    f = frame_len(i);
    s = imax(k + 1, free_at[i]);
    for (int j = 0; j < f; j++) begin
      if (s + j < NMAX) begin
        if (j < CPB)          exp_txd[i][s + j] = 1'b0;
        else if (j < 9 * CPB) exp_txd[i][s + j] = d[j / CPB - 1];
        else                  exp_txd[i][s + j] = 1'b1;
      end
    end
    if (s + f - 1 < NMAX) exp_done[i][s + f - 1] = 1'b1;
    hold_until[i] = s;
    free_at[i]    = s + f;
    busy_until[i] = s + f;
    acc_at[i]     = k;
  endtask

  // BREAK requested on edge k: needs one idle cycle after any traffic ahead of it.
  task automatic model_break(input int i, input int k);
    int b;
    if (k < last_b[i]) return;  // already pending
    b = imax(k + 1, free_at[i] + 1);
    for (int j = 0; j < BB * CPB; j++)
      if (b + j < NMAX) exp_txd[i][b + j] = 1'b0;
    last_b[i]     = b;
    free_at[i]    = b + (BB + 1) * CPB;
    brk_until[i]  = free_at[i];
    busy_until[i] = free_at[i];
  endtask

  task automatic chk(input string tag, input int i, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s inst%0d cyc=%0d observed=%b expected=%b", tag, i, cyc, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int i, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s inst%0d cyc=%0d observed=%0d expected=%0d", tag, i, cyc, obs, expv);
    end
  endtask

  task automatic step();
    logic [1:0] acc;
    logic       brk;
    logic       rst;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) acc[i] = en[i] && ready_exp(i, cyc);
    brk = send_break && !reset;
    rst = reset;
    d   = send_data;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        model_reset(i, cyc);
      end else begin
        if (acc[i]) model_byte(i, cyc, d);
        if (brk)    model_break(i, cyc);
      end
    end
    last_acc = rst ? 2'b00 : acc;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("txd",   i, txd[i],   exp_txd[i][cyc]);
      chk("done",  i, done[i],  exp_done[i][cyc]);
      chk("ready", i, ready[i], ready_exp(i, cyc));
      chk("busy",  i, busy[i],  logic'(cyc < busy_until[i]));
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        done_at[i] = cyc;
      end
      if (txd[i] === 1'b0) low_cnt[i]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic offer(input logic [7:0] d);
    int n;
    n = 0;
    send_data = d;
    en = 2'b11;
    while (en != 2'b00 && n < 400) begin
      step();
      en = en & ~last_acc;
      n++;
    end
    en = 2'b00;
    send_data = 8'($urandom);  // data may change freely after acceptance
    checks++;
    assert (n < 400) else begin
      errors++;
      $error("FAIL offer_timeout observed=%0d expected<400", n);
    end
  endtask

  task automatic pulse_break();
    send_break = 1'b1;
    step();
    send_break = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cyc < busy_until[0] || cyc < busy_until[1]) && n < 3000) begin
      step();
      n++;
    end
    run(3);
    checks++;
    assert (n < 3000) else begin
      errors++;
      $error("FAIL idle_timeout observed=%0d expected<3000", n);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      low_cnt[i]  = 0;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    reset = 1'b1;
    en = 2'b00;
    send_data = 8'h00;
    send_break = 1'b0;
    last_acc = 2'b00;
    for (int i = 0; i < 2; i++) begin
      model_reset(i, 0);
      acc_at[i] = 0;
      done_at[i] = 0;
    end
    clear_counts();

    // Reset state, then ready rises on the first cycle after release.
    run(3);
    reset = 1'b0;
    run(2);

    // Single byte 0xA5: done lands one frame period after acceptance (100 / 110 cycles).
    clear_counts();
    offer(8'hA5);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk_int("a5_done_cnt", i, done_cnt[i], 1);
      chk_int("a5_done_lat", i, done_at[i] - acc_at[i], (i == 0) ? 100 : 110);
    end

    // Back-to-back 0x00 then 0xFF with no idle gap.
    clear_counts();
    offer(8'h00);
    offer(8'hFF);
    wait_idle();
    for (int i = 0; i < 2; i++) chk_int("b2b_done_cnt", i, done_cnt[i], 2);

    // Third byte offered while hold is full is dropped.
    clear_counts();
    offer(8'h12);
    offer(8'h34);
    run(5);
    send_data = 8'h77;
    en = 2'b11;
    step();
    en = 2'b00;
    wait_idle();
    for (int i = 0; i < 2; i++) chk_int("drop_done_cnt", i, done_cnt[i], 2);

    // BREAK requested mid-frame: 0x55 has 5 low bits (start + four zeros), then 110 low.
    clear_counts();
    offer(8'h55);
    run(30);
    pulse_break();
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk_int("brk_done_cnt", i, done_cnt[i], 1);
      chk_int("brk_low_cycles", i, low_cnt[i], 50 + 110);
    end

    // Reset at cycle 45 of a frame aborts it silently; 0x3C then goes out cleanly.
    clear_counts();
    offer(8'hC3);
    while (cyc < acc_at[0] + 45) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) chk_int("rst_done_cnt", i, done_cnt[i], 0);
    offer(8'h3C);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk_int("3c_done_cnt", i, done_cnt[i], 1);
      chk_int("3c_done_lat", i, done_at[i] - acc_at[i], (i == 0) ? 100 : 110);
    end

    // Random traffic: offers at random times (many while not ready) and occasional BREAKs.
    for (int t = 0; t < 1500; t++) begin
      send_data  = 8'($urandom);
      en         = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      send_break = ($urandom_range(0, 199) == 0);
      step();
    end
    en = 2'b00;
    send_break = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
